// File: rtl/acoustics_cmd_initiator.sv
// -----------------------------------------------------------------------------
// acoustics_cmd_initiator
//
// Host-side issuer of the acoustics single-byte UART command protocol.
// A local request (set frequency, set threshold, read max, trigger detect) is
// encoded into one command byte and handed to the UART transmitter. For read
// ops the response bytes are then collected and decoded under a timeout.
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   req_valid/req_ready     request handshake; req_op selects the command,
//                           req_arg carries the frequency index / threshold
//   tx_data/tx_write_en     command byte towards UART TX, held until tx_ready
//   tx_ready                UART TX accepts tx_data this cycle
//   rx_ready/rx_data        one-cycle pulse carrying a received byte
//   rsp_valid               one-cycle pulse, transaction complete
//   rsp_data                read-max value (MSB first) or {8'h00, raw byte}
//   rsp_trigger             trigger-detect result
//   rsp_timeout             transaction ended by response timeout
//   rsp_error               trigger response matched neither code
//   busy                    high whenever not idle
// -----------------------------------------------------------------------------
module acoustics_cmd_initiator #(
  parameter int unsigned MAX_RESP_BYTES = 2,
  parameter logic [7:0]  TRUE_CODE      = 8'h01,
  parameter logic [7:0]  FALSE_CODE     = 8'h00,
  parameter int unsigned RESP_TIMEOUT   = 100000,
  parameter int unsigned TRIG_TIMEOUT   = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [6:0]  req_arg,
  output logic [7:0]  tx_data,
  output logic        tx_write_en,
  input  logic        tx_ready,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_trigger,
  output logic        rsp_timeout,
  output logic        rsp_error,
  output logic        busy
);

  localparam int unsigned MAX_TIMEOUT =
    (RESP_TIMEOUT > TRIG_TIMEOUT) ? RESP_TIMEOUT : TRIG_TIMEOUT;
  localparam int CNT_W = $clog2(MAX_TIMEOUT) + 1;

  // The terminal cycle is the one in which the counter holds limit-1; the
  // edge closing it moves to DONE with the counter saturated at the limit.
  localparam logic [CNT_W-1:0] RESP_LIMIT = CNT_W'(RESP_TIMEOUT);
  localparam logic [CNT_W-1:0] TRIG_LIMIT = CNT_W'(TRIG_TIMEOUT);
  localparam logic [CNT_W-1:0] RESP_TERM  = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TRIG_TERM  = CNT_W'(TRIG_TIMEOUT - 1);
  localparam logic [1:0]       BYTE_LAST  = 2'(MAX_RESP_BYTES - 1);

  localparam logic [1:0] OP_SET_FREQ  = 2'b00;
  localparam logic [1:0] OP_SET_THR   = 2'b01;
  localparam logic [1:0] OP_READ_MAX  = 2'b10;
  localparam logic [1:0] OP_TRIG_DET  = 2'b11;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       byte_cnt;
  logic [7:0]       cmd_byte;
  logic             is_read;
  logic             terminal;
  logic             last_byte;

  // Command encoding of the incoming request.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cmd_byte = 8'h50;
    case (req_op)
      OP_SET_FREQ: cmd_byte = {4'h7, req_arg[3:0]};
      OP_SET_THR:  cmd_byte = {1'b1, req_arg};
      OP_READ_MAX: cmd_byte = 8'h40;
      OP_TRIG_DET: cmd_byte = 8'h50;
      default:     cmd_byte = 8'h50;
    endcase
  end

  assign is_read   = (op_q == OP_READ_MAX);
  assign terminal  = (cnt == (is_read ? RESP_TERM : TRIG_TERM));
  assign last_byte = (byte_cnt == BYTE_LAST);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    tx_write_en = 1'b0;
    rsp_valid   = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nxt = SEND;
      end
      SEND: begin
        tx_write_en = 1'b1;
        if (tx_ready) state_nxt = op_q[1] ? WAIT_RESP : DONE;
      end
      WAIT_RESP: begin
        // A byte arriving on the terminal cycle takes priority over timeout.
        if (rx_ready) begin
          if (!is_read || last_byte) state_nxt = DONE;
        end else if (terminal) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, response collection and timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= OP_SET_FREQ;
      tx_data     <= 8'h00;
      cnt         <= '0;
      byte_cnt    <= 2'd0;
      rsp_data    <= 16'h0000;
      rsp_trigger <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_error   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q        <= req_op;
            tx_data     <= cmd_byte;
            cnt         <= '0;
            byte_cnt    <= 2'd0;
            rsp_data    <= 16'h0000;
            rsp_trigger <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_error   <= 1'b0;
          end
        end
        SEND: begin
          if (tx_ready) begin
            cnt      <= '0;
            byte_cnt <= 2'd0;
          end
        end
        WAIT_RESP: begin
          if (rx_ready) begin
            cnt <= '0;
            if (is_read) begin
              rsp_data <= {rsp_data[7:0], rx_data};
              byte_cnt <= byte_cnt + 2'd1;
            end else begin
              rsp_data <= {8'h00, rx_data};
              if (rx_data == TRUE_CODE)       rsp_trigger <= 1'b1;
              else if (rx_data == FALSE_CODE) rsp_trigger <= 1'b0;
              else                            rsp_error   <= 1'b1;
            end
          end else begin
            if (terminal) rsp_timeout <= 1'b1;
            if (cnt != (is_read ? RESP_LIMIT : TRIG_LIMIT))
              cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/acoustics_cmd_initiator.md
Name: acoustics_cmd_initiator

Overview:
Host-side issuer of the acoustics single-byte UART command protocol. Takes a local request (set frequency, set threshold, read max, trigger detect) and encodes the command byte. Pushes the byte into the UART transmitter, then collects and decodes the response bytes, enforcing a response timeout. Sits between a local sequencer or test harness and a UART TX/RX pair wired to the acoustics board.

Parameters:
MAX_RESP_BYTES, 2, number of bytes returned for a read-max command, MSB first (1..2)
TRUE_CODE, 8'h01, response byte meaning "trigger detected"
FALSE_CODE, 8'h00, response byte meaning "no trigger / far-end timeout"
RESP_TIMEOUT, 100000, clk cycles allowed between command transfer (or previous response byte) and each read-max response byte
TRIG_TIMEOUT, 2000000, clk cycles allowed for the trigger-detect response byte; set larger than the far-end detect timeout

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_op  in  2  00 set frequency, 01 set threshold, 10 read max, 11 trigger detect
req_arg  in  7  argument: frequency index in [3:0] or threshold in [6:0]
tx_data  out  8  command byte to UART TX
tx_write_en  out  1  tx_data valid
tx_ready  in  1  UART TX accepts tx_data this cycle
rx_ready  in  1  one-cycle pulse, rx_data valid
rx_data  in  8  received byte
rsp_valid  out  1  one-cycle pulse, transaction complete
rsp_data  out  16  read-max value, or {8'h00, raw byte} for trigger detect
rsp_trigger  out  1  trigger-detect result
rsp_timeout  out  1  transaction ended by timeout
rsp_error  out  1  trigger response byte matched neither code
busy  out  1  high whenever not in IDLE

Behaviour:
- Fixed reset and synchronous-reset rules:
  - All state changes are on the clk rising edge. The reset is synchronous and active-high.
  - Reset value: state IDLE, req_ready=1, busy=0. tx_write_en, tx_data, rsp_valid, rsp_data, rsp_trigger, rsp_timeout, rsp_error and the timeout counter are all 0.
  - Reset mid-transaction abandons it. tx_write_en drops at that edge, no rsp_valid is produced, and any partial response is discarded.
- Encoding, applied on accept:
  - op00 gives {4'h7, arg[3:0]}.
  - op01 gives {1'b1, arg[6:0]}.
  - op10 gives 8'h40.
  - op11 gives 8'h50.
- States: IDLE, SEND, WAIT_RESP, DONE.
- IDLE:
  - req_ready=1.
  - When req_valid && req_ready, latch op and the encoded byte into tx_data and go to SEND. req_ready=0 and tx_write_en=1 from the next cycle.
  - rx_ready pulses in IDLE are discarded.
- SEND:
  - Hold tx_write_en=1 and tx_data stable until the cycle where tx_ready=1. That cycle is the transfer.
  - Next edge: tx_write_en=0.
  - Set ops (00/01) go to DONE.
  - Ops 10/11 go to WAIT_RESP with counter=0 and byte count=0.
  - rx bytes arriving in SEND are discarded.
- WAIT_RESP:
  - The counter increments each cycle. The limit is RESP_TIMEOUT for op10 and TRIG_TIMEOUT for op11.
  - op10: each rx_ready shifts rx_data into rsp_data (rsp_data <= {rsp_data[7:0], rx_data}, cleared on accept) and resets the counter. After MAX_RESP_BYTES bytes, go to DONE.
  - op11: the first rx_ready stores rsp_data={8'h00, rx_data}.
    - Byte equal to TRUE_CODE sets rsp_trigger=1.
    - Byte equal to FALSE_CODE sets rsp_trigger=0.
    - Any other byte sets rsp_error=1.
    - Then go to DONE.
  - Counter reaching its limit goes to DONE with rsp_timeout=1. A partial read-max value is left in rsp_data.
  - If rx_ready and the terminal count coincide, the byte wins: it is accepted and the counter resets.
- DONE:
  - rsp_valid=1 for exactly one cycle, then IDLE with req_ready=1.
  - Minimum latency for a set op is accept, then 1 cycle after tx_ready, then rsp_valid.
- Result holding:
  - rsp_data, rsp_trigger, rsp_timeout and rsp_error hold until the next accept.
  - On accept, all four clear to 0.
- req_valid while busy is ignored; no queuing.
- Counter width: $clog2 of the larger timeout, plus 1. The counter never wraps; it saturates at terminal count.

Test Plan:
- Set threshold: req_op=01, req_arg=7'h2A, tx_ready held 0 for 5 cycles then 1 → tx_data=8'hAA held with tx_write_en=1 for 6 cycles; rsp_valid pulses once 1 cycle after transfer, all flags 0.
- Set frequency: req_op=00, req_arg=7'h7F → tx_data=8'h7F (upper arg bits ignored); a req_valid pulse during SEND is not accepted.
- Read max: op=10, rx bytes 8'h12 then 8'h34 spaced 50 cycles apart → rsp_data=16'h1234, rsp_valid once, rsp_timeout=0. Second case with RESP_TIMEOUT=64 and only 8'h12 sent → rsp_timeout=1, rsp_data=16'h0012 exactly 64 cycles after that byte.
- Trigger detect: op=11, rx 8'h01 → rsp_trigger=1. Rx 8'h00 → rsp_trigger=0. Rx 8'h55 → rsp_error=1, rsp_data=16'h0055.
- Boundary: rx_ready on the same cycle the counter hits the limit → byte accepted, rsp_timeout=0. Stray rx_ready in IDLE → no rsp_valid, state unchanged.
- Reset asserted mid WAIT_RESP and mid SEND → all outputs return to reset values next edge; no rsp_valid; the next request completes normally.
